// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    OUT
  } uart_fp_state_t;

  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_BAD_CHK = 2'd2,
    ERR_TIMEOUT = 2'd3
  } uart_fp_err_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pl_buf.sv
// Payload buffer: register array with one synchronous write port and an
// asynchronous read port, so the drain side sees a byte in the same cycle
// its pointer changes.
module uart_pl_buf #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [7:0]       din,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [7:0]       dout
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte whenever the parser is collecting data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser for the UART RX byte stream: SOF, LEN, payload, CHK.
// Payload is held in a local buffer and only released downstream after
// the XOR checksum matches; bad or stalled frames are dropped and flagged.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF         = SOF_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 520_800
) (
  input  logic       i_clk_sys,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_pl_valid,
  input  logic       i_pl_ready,
  output logic [7:0] o_pl_data,
  output logic       o_pl_last,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  // A single-entry buffer still needs a one-bit pointer.
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  // The timer "reaches" TIMEOUT_CYC-1 on the edge where it is currently one below that.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 2);

  uart_fp_state_t   state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       chk_q, chk_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  uart_fp_err_t     code_q, code_d;

  logic             buf_we;
  logic [7:0]       buf_dout;
  logic [7:0]       len_m1;
  logic             last_wr;
  logic             last_rd;
  logic             timed_state;
  logic             timeout_hit;

  uart_pl_buf #(
    .DEPTH (MAX_LEN),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk    (i_clk_sys),
    .we     (buf_we),
    .wr_ptr (wr_q),
    .din    (i_rx_data),
    .rd_ptr (rd_q),
    .dout   (buf_dout)
  );

  assign len_m1      = len_q - 8'd1;
  assign last_wr     = (8'(wr_q) == len_m1);
  assign last_rd     = (8'(rd_q) == len_m1);
  assign timed_state = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  // An arriving byte always beats an expiring timer.
  assign timeout_hit = timed_state && !i_rx_valid && (timer_q == TMR_LAST);

  // Next-state, datapath updates and pulse generation for the frame FSM.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_OVERRUN;
    buf_we  = 1'b0;

    if (!timed_state || i_rx_valid) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_rx_valid && (i_rx_data == SOF)) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (i_rx_valid) begin
          if ((i_rx_data != 8'd0) && (i_rx_data <= MAX_LEN_B)) begin
            len_d   = i_rx_data;
            chk_d   = i_rx_data;
            wr_d    = '0;
            state_d = DATA;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (i_rx_valid) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ i_rx_data;
          if (last_wr) begin
            state_d = CHK;
          end else begin
            wr_d = wr_q + 1'b1;
          end
        end
      end
      CHK: begin
        if (i_rx_valid) begin
          if (i_rx_data == chk_q) begin
            ok_d    = 1'b1;
            rd_d    = '0;
            state_d = OUT;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_CHK;
            state_d = IDLE;
          end
        end
      end
      OUT: begin
        if (i_rx_valid) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (i_pl_ready) begin
          if (last_rd) begin
            state_d = IDLE;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = IDLE;
    end
  end

  // State, datapath and pulse registers; reset drops any frame in flight.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      chk_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      timer_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_OVERRUN;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      timer_q <= timer_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_pl_valid  = (state_q == OUT);
  assign o_pl_data   = o_pl_valid ? buf_dout : 8'h00;
  assign o_pl_last   = o_pl_valid && last_rd;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a payload scoreboard.
module tb_uart_frame_parser;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 40;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       pl_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int valid_cycles = 0;
  logic [8:0] sb_q[$];

  uart_frame_parser #(
    .SOF         (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk_sys   (clk),
    .i_rst_n     (rst_n),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_pl_valid  (pl_valid),
    .i_pl_ready  (pl_ready),
    .o_pl_data   (pl_data),
    .o_pl_last   (pl_last),
    .o_frame_ok  (frame_ok),
    .o_frame_err (frame_err),
    .o_err_code  (err_code),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one received byte for a single clock; caller sits just after a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
    checkOutput({pfx, "_pl_valid"}, 32'(pl_valid), 32'd0);
    checkOutput({pfx, "_pl_last"}, 32'(pl_last), 32'd0);
    checkOutput({pfx, "_pl_data"}, 32'(pl_data), 32'd0);
    checkOutput({pfx, "_frame_ok"}, 32'(frame_ok), 32'd0);
    checkOutput({pfx, "_frame_err"}, 32'(frame_err), 32'd0);
    checkOutput({pfx, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  // Monitor: count pulses and check every accepted payload byte against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (pl_valid) valid_cycles++;
      if (pl_valid && pl_ready) begin
        checkOutput("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          logic [8:0] e;
          e = sb_q.pop_front();
          checkOutput("sb_pl_data", 32'(pl_data), 32'(e[7:0]));
          checkOutput("sb_pl_last", 32'(pl_last), 32'(e[8]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ok0, err0, val0, n;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pl_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame with ready held high
    ok0  = ok_cnt;
    val0 = valid_cycles;
    sb_q.push_back({1'b0, 8'h11});
    sb_q.push_back({1'b0, 8'h22});
    sb_q.push_back({1'b1, 8'h33});
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h03);
    checkOutput("good_ok_pulse", 32'(frame_ok), 32'd1);
    checkOutput("good_first_valid", 32'(pl_valid), 32'd1);
    checkOutput("good_first_data", 32'(pl_data), 32'h11);
    waitCycles(2);
    checkOutput("good_last_data", 32'(pl_data), 32'h33);
    checkOutput("good_last_flag", 32'(pl_last), 32'd1);
    checkOutput("good_busy_drain", 32'(busy), 32'd1);
    waitCycles(1);
    checkOutput("good_busy_done", 32'(busy), 32'd0);
    checkOutput("good_valid_done", 32'(pl_valid), 32'd0);
    checkOutput("good_ok_count", 32'(ok_cnt - ok0), 32'd1);
    checkOutput("good_valid_cycles", 32'(valid_cycles - val0), 32'd3);

    // Bad checksum
    err0 = err_cnt;
    val0 = valid_cycles;
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    checkOutput("badchk_err", 32'(frame_err), 32'd1);
    checkOutput("badchk_code", 32'(err_code), 32'd2);
    checkOutput("badchk_ok", 32'(frame_ok), 32'd0);
    waitCycles(3);
    checkOutput("badchk_err_count", 32'(err_cnt - err0), 32'd1);
    checkOutput("badchk_no_valid", 32'(valid_cycles - val0), 32'd0);
    checkOutput("badchk_busy", 32'(busy), 32'd0);

    // Bad lengths: zero and one over MAX_LEN
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    checkOutput("badlen0_err", 32'(frame_err), 32'd1);
    checkOutput("badlen0_code", 32'(err_code), 32'd1);
    checkOutput("badlen0_busy", 32'(busy), 32'd0);
    waitCycles(1);
    applyStimulus(8'hA5);
    applyStimulus(8'h11);
    checkOutput("badlen17_err", 32'(frame_err), 32'd1);
    checkOutput("badlen17_code", 32'(err_code), 32'd1);
    checkOutput("badlen17_busy", 32'(busy), 32'd0);
    waitCycles(1);

    // Backpressure and overrun
    pl_ready = 1'b0;
    sb_q.push_back({1'b1, 8'h5A});
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h5A);
    applyStimulus(8'h5B);
    checkOutput("bp_ok", 32'(frame_ok), 32'd1);
    waitCycles(5);
    checkOutput("bp_hold_valid", 32'(pl_valid), 32'd1);
    checkOutput("bp_hold_data", 32'(pl_data), 32'h5A);
    checkOutput("bp_hold_last", 32'(pl_last), 32'd1);
    applyStimulus(8'h33);
    checkOutput("ovr_err", 32'(frame_err), 32'd1);
    checkOutput("ovr_code", 32'(err_code), 32'd0);
    checkOutput("ovr_still_valid", 32'(pl_valid), 32'd1);
    waitCycles(13);
    checkOutput("bp_late_data", 32'(pl_data), 32'h5A);
    checkOutput("bp_late_busy", 32'(busy), 32'd1);
    pl_ready = 1'b1;
    waitCycles(1);
    checkOutput("bp_drained_busy", 32'(busy), 32'd0);
    checkOutput("bp_drained_valid", 32'(pl_valid), 32'd0);

    // Timeout inside DATA
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    n = 0;
    while (!frame_err && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("tmo_latency", 32'(n), 32'(TIMEOUT_CYC - 1));
    checkOutput("tmo_code", 32'(err_code), 32'd3);
    checkOutput("tmo_busy", 32'(busy), 32'd0);
    waitCycles(1);

    // Noise then a good frame
    err0 = err_cnt;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("noise_busy", 32'(busy), 32'd0);
    sb_q.push_back({1'b1, 8'h7E});
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h7E);
    applyStimulus(8'h7F);
    checkOutput("resync_ok", 32'(frame_ok), 32'd1);
    checkOutput("resync_data", 32'(pl_data), 32'h7E);
    checkOutput("resync_last", 32'(pl_last), 32'd1);
    waitCycles(1);
    checkOutput("resync_busy", 32'(busy), 32'd0);
    checkOutput("resync_no_err", 32'(err_cnt - err0), 32'd0);

    // Reset pulsed during DATA, then a fresh frame
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    checkOutput("rst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back({1'b0, 8'hC3});
    sb_q.push_back({1'b1, 8'h3C});
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'hC3);
    applyStimulus(8'h3C);
    applyStimulus(8'hFD);
    checkOutput("post_rst_ok", 32'(frame_ok), 32'd1);
    checkOutput("post_rst_data", 32'(pl_data), 32'hC3);
    waitCycles(2);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
